// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forwarding controller for the 5-stage pipeline
// Optional macro HAZARD_CTRL_FWD_EN: EX forwarding on; without it any RAW match stalls.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_MemRead,
  input  logic             idex_RegWrite,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_RegWrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_RegWrite,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait;
  logic              raw_stall;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;

  // Source dependency on a producer that will write rd (x0 never creates a hazard).
  function automatic logic dep(input logic use_src, input logic [4:0] src,
                               input logic wr, input logic [4:0] rd);
    return use_src && wr && (rd != 5'd0) && (src == rd);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic ex_wr, input logic [4:0] ex_rd,
                                         input logic wb_wr, input logic [4:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_wr && ex_rd != 5'd0 && ex_rd == src)
      sel = 2'b10;
    else if (wb_wr && wb_rd != 5'd0 && wb_rd == src)
      sel = 2'b01;
    return sel;
  endfunction

  assign mem_wait = (state == RUN) ? (mem_req && !mem_ready) : !mem_ready;

  always_comb begin
    raw_stall = dep(id_use_rs1, id_rs1, idex_MemRead, idex_rd) ||
                dep(id_use_rs2, id_rs2, idex_MemRead, idex_rd);
`ifndef HAZARD_CTRL_FWD_EN
    // Without forwarding every in-flight producer blocks its consumer in ID.
    if (dep(id_use_rs1, id_rs1, idex_RegWrite, idex_rd)   ||
        dep(id_use_rs2, id_rs2, idex_RegWrite, idex_rd)   ||
        dep(id_use_rs1, id_rs1, exmem_RegWrite, exmem_rd) ||
        dep(id_use_rs2, id_rs2, exmem_RegWrite, exmem_rd) ||
        dep(id_use_rs1, id_rs1, memwb_RegWrite, memwb_rd) ||
        dep(id_use_rs2, id_rs2, memwb_RegWrite, memwb_rd))
      raw_stall = 1'b1;
`endif
  end

`ifdef HAZARD_CTRL_FWD_EN
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = idex_RegWrite;
  assign fwd_a_sel = fwd_sel(idex_rs1, exmem_RegWrite, exmem_rd, memwb_RegWrite, memwb_rd);
  assign fwd_b_sel = fwd_sel(idex_rs2, exmem_RegWrite, exmem_rd, memwb_RegWrite, memwb_rd);
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{idex_rs1, idex_rs2,
                               fwd_sel(idex_rs1, exmem_RegWrite, exmem_rd,
                                       memwb_RegWrite, memwb_rd)};
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_req && !mem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Priority: reset > memory wait > branch flush > RAW stall.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    fwd_a       = fwd_a_sel;
    fwd_b       = fwd_b_sel;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
    end else if (mem_wait) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (raw_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN) begin
        if (state_nxt == MEM_WAIT) wait_cnt <= '0;
      end else begin
        // Timeout only flags the error; the access keeps waiting for mem_ready.
        if (wait_cnt == WAIT_LAST) mem_err <= 1'b1;
        if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
      end
      if (!pc_en && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
